// File: rtl/mem_rsp_pkg.sv
// Shared definitions for the toggle req/ack memory responder.
// State encoding and byte-strobe constants used by the responder and its helpers.
package mem_rsp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        ISSUE   = 3'd2,
        RDWAIT  = 3'd3,
        REFRESH = 3'd4
    } state_e;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = DS_HI | DS_LO;

endpackage

// File: rtl/mem_rsp_checker.sv
// Protocol checker for the responder: the initiator must not toggle mem_req
// while a request is being served.
module mem_rsp_checker (
    input logic clk,
    input logic reset,
    input logic busy_i,
    input logic mem_req_i
);

    a_req_stable_while_busy: assert property (
        @(posedge clk) disable iff (reset) busy_i |-> $stable(mem_req_i)
    );

endmodule

// File: rtl/mem_rsp_refresh_timer.sv
// Free-running refresh period counter with a sticky due flag.
// Only instantiated when MEM_RSP_REFRESH_EN is defined.
module mem_rsp_refresh_timer #(
    parameter int PERIOD = 780
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic due_o
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic          due_q;

    // Count the period; raising due wins over a clear in the same cycle so no refresh is lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            due_q <= 1'b0;
        end else begin
            if (cnt_q == LAST) begin
                cnt_q <= '0;
                due_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
                if (clr_i) begin
                    due_q <= 1'b0;
                end
            end
        end
    end

    assign due_o = due_q;

endmodule

// File: rtl/mem_toggle_responder.sv
// Responder end of the 16-bit toggle req/ack memory port.
// A request is pending while mem_req != mem_req_ack; it is executed on a
// synchronous single-port RAM and completed by toggling mem_req_ack.
// Optional feature macro: MEM_RSP_REFRESH_EN (periodic refresh stalls).
module mem_toggle_responder
    import mem_rsp_pkg::*;
#(
    parameter int AW             = 22,
    parameter int WAIT_CYCLES    = 2,
    parameter int RAM_RD_LAT     = 1,
    parameter int REFRESH_PERIOD = 780,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW:1]   mem_addr,
    input  logic          mem_req,
    input  logic [1:0]    mem_ds,
    input  logic [15:0]   mem_din,
    input  logic          mem_we,
    output logic          mem_req_ack,
    output logic [15:0]   mem_dout,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [1:0]    ram_be,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_wdata,
    input  logic [15:0]   ram_rdata
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || RAM_RD_LAT < 1 || RAM_RD_LAT > 2 ||
        REFRESH_CYCLES < 1 || REFRESH_PERIOD <= REFRESH_CYCLES) begin : g_bad_cfg
        $error("mem_toggle_responder: unsupported parameter set");
    end

    localparam logic [3:0] WCNT_INIT  = 4'(WAIT_CYCLES - 1);
    localparam logic       RDCNT_INIT = 1'(RAM_RD_LAT - 1);

    state_e        state_q;
    logic [3:0]    wcnt_q;
    logic          rdcnt_q;
    logic          we_q;
    logic          mem_req_ack_q;
    logic [15:0]   mem_dout_q;
    logic          ram_cs_q;
    logic          ram_we_q;
    logic [1:0]    ram_be_q;
    logic [AW-1:0] ram_addr_q;
    logic [15:0]   ram_wdata_q;

    logic          pending_s;
    logic          accept_s;
    logic          busy_s;

`ifdef MEM_RSP_REFRESH_EN
    localparam int RCW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RCW-1:0] RCNT_INIT = RCW'(REFRESH_CYCLES - 1);

    logic [RCW-1:0] rcnt_q;
    logic           refresh_due_s;
    logic           refresh_clr_s;

    mem_rsp_refresh_timer #(
        .PERIOD (REFRESH_PERIOD)
    ) u_refresh_timer (
        .clk   (clk),
        .reset (reset),
        .clr_i (refresh_clr_s),
        .due_o (refresh_due_s)
    );
`endif

    // Decide whether a pending request is taken this cycle; refresh has priority in IDLE,
    // and the last refresh cycle already counts as idle so a deferred request waits no longer
    always_comb begin
        pending_s = mem_req ^ mem_req_ack_q;
`ifdef MEM_RSP_REFRESH_EN
        refresh_clr_s = (state_q == IDLE) && refresh_due_s;
        if (state_q == IDLE) begin
            accept_s = pending_s && !refresh_due_s;
        end else if (state_q == REFRESH) begin
            accept_s = pending_s && (rcnt_q == '0);
        end else begin
            accept_s = 1'b0;
        end
`else
        if (state_q == IDLE) begin
            accept_s = pending_s;
        end else begin
            accept_s = 1'b0;
        end
`endif
    end

    assign busy_s = (state_q == WAIT) || (state_q == ISSUE) || (state_q == RDWAIT);

    // Request sequencer: latch, wait states, single-cycle RAM strobe, read capture and ack toggle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wcnt_q        <= 4'd0;
            rdcnt_q       <= 1'b0;
            we_q          <= 1'b0;
            mem_req_ack_q <= 1'b0;
            mem_dout_q    <= 16'h0000;
            ram_cs_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_be_q      <= 2'b00;
            ram_addr_q    <= '0;
            ram_wdata_q   <= 16'h0000;
`ifdef MEM_RSP_REFRESH_EN
            rcnt_q        <= '0;
`endif
        end else begin
            ram_cs_q <= 1'b0;
            ram_we_q <= 1'b0;
            if (accept_s) begin
                we_q        <= mem_we;
                ram_addr_q  <= mem_addr;
                ram_wdata_q <= mem_din;
                ram_be_q    <= mem_we ? mem_ds : DS_BOTH;
                if (WAIT_CYCLES == 0) begin
                    state_q  <= ISSUE;
                    ram_cs_q <= 1'b1;
                    ram_we_q <= mem_we;
                end else begin
                    state_q <= WAIT;
                    wcnt_q  <= WCNT_INIT;
                end
            end else begin
                case (state_q)
                    IDLE: begin
`ifdef MEM_RSP_REFRESH_EN
                        if (refresh_due_s) begin
                            state_q <= REFRESH;
                            rcnt_q  <= RCNT_INIT;
                        end
`endif
                    end
                    WAIT: begin
                        if (wcnt_q == 4'd0) begin
                            state_q  <= ISSUE;
                            ram_cs_q <= 1'b1;
                            ram_we_q <= we_q;
                        end else begin
                            wcnt_q <= wcnt_q - 4'd1;
                        end
                    end
                    ISSUE: begin
                        if (we_q) begin
                            mem_req_ack_q <= ~mem_req_ack_q;
                            state_q       <= IDLE;
                        end else begin
                            rdcnt_q <= RDCNT_INIT;
                            state_q <= RDWAIT;
                        end
                    end
                    RDWAIT: begin
                        if (rdcnt_q == 1'b0) begin
                            mem_dout_q    <= ram_rdata;
                            mem_req_ack_q <= ~mem_req_ack_q;
                            state_q       <= IDLE;
                        end else begin
                            rdcnt_q <= 1'b0;
                        end
                    end
                    REFRESH: begin
`ifdef MEM_RSP_REFRESH_EN
                        if (rcnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            rcnt_q <= rcnt_q - RCW'(1);
                        end
`else
                        state_q <= IDLE;
`endif
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_req_ack = mem_req_ack_q;
    assign mem_dout    = mem_dout_q;
    assign ram_cs      = ram_cs_q;
    assign ram_we      = ram_we_q;
    assign ram_be      = ram_be_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;

    mem_rsp_checker u_checker (
        .clk       (clk),
        .reset     (reset),
        .busy_i    (busy_s),
        .mem_req_i (mem_req)
    );

endmodule

// File: tb/tb_mem_toggle_responder.sv
// Bench for mem_toggle_responder: instance 0 uses WAIT_CYCLES=2/RAM_RD_LAT=1,
// instance 1 uses WAIT_CYCLES=0/RAM_RD_LAT=2. Each drives its own byte-enabled RAM.
`timescale 1ns/1ps
module tb_mem_toggle_responder;

    localparam int AW = 8;
    localparam int NI = 2;
    localparam int RP = 16;
    localparam int RC = 4;

    function automatic int wc_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int rl_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic [15:0] fill_val(input logic [7:0] a);
        return {a, ~a};
    endfunction

    logic clk = 1'b0;
    logic reset;
    logic fill;

    logic [NI-1:0]           mem_req, mem_we, mem_req_ack, ram_cs, ram_we;
    logic [NI-1:0][AW-1:0]   mem_addr, ram_addr;
    logic [NI-1:0][1:0]      mem_ds, ram_be;
    logic [NI-1:0][15:0]     mem_din, mem_dout, ram_wdata, ram_rdata;

    logic [15:0] ram_arr [NI][256];
    logic [15:0] rd1 [NI];
    logic [15:0] rd2 [NI];
    int          cs_cnt [NI];
    int          wr_cnt [NI];
    logic [1:0]  last_be [NI];

    logic [15:0] model_mem [NI][256];
    logic [15:0] last_rd [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_toggle_responder #(
            .AW             (AW),
            .WAIT_CYCLES    (wc_of(g)),
            .RAM_RD_LAT     (rl_of(g)),
            .REFRESH_PERIOD (RP),
            .REFRESH_CYCLES (RC)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .mem_addr    (mem_addr[g]),
            .mem_req     (mem_req[g]),
            .mem_ds      (mem_ds[g]),
            .mem_din     (mem_din[g]),
            .mem_we      (mem_we[g]),
            .mem_req_ack (mem_req_ack[g]),
            .mem_dout    (mem_dout[g]),
            .ram_cs      (ram_cs[g]),
            .ram_we      (ram_we[g]),
            .ram_be      (ram_be[g]),
            .ram_addr    (ram_addr[g]),
            .ram_wdata   (ram_wdata[g]),
            .ram_rdata   (ram_rdata[g])
        );
    end

    // Environment RAMs: byte-enabled writes, read data valid 1 or 2 cycles after the strobe, junk otherwise
    always @(posedge clk) begin
        for (int d = 0; d < NI; d++) begin
            if (fill) begin
                for (int i = 0; i < 256; i++) ram_arr[d][i] <= fill_val(8'(i));
                cs_cnt[d]  <= 0;
                wr_cnt[d]  <= 0;
                last_be[d] <= 2'b00;
            end else if (ram_cs[d]) begin
                cs_cnt[d]  <= cs_cnt[d] + 1;
                last_be[d] <= ram_be[d];
                if (ram_we[d]) begin
                    wr_cnt[d] <= wr_cnt[d] + 1;
                    if (ram_be[d][0]) ram_arr[d][ram_addr[d]][7:0]  <= ram_wdata[d][7:0];
                    if (ram_be[d][1]) ram_arr[d][ram_addr[d]][15:8] <= ram_wdata[d][15:8];
                end
            end
            if (ram_cs[d] && !ram_we[d]) rd1[d] <= ram_arr[d][ram_addr[d]];
            else                         rd1[d] <= 16'($urandom);
            rd2[d] <= rd1[d];
        end
    end

    // Select the read pipeline stage matching each instance's read latency
    always_comb begin
        for (int d = 0; d < NI; d++) ram_rdata[d] = (rl_of(d) == 1) ? rd1[d] : rd2[d];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_lat(input string nm, input int lat, input int base);
        total++;
`ifdef MEM_RSP_REFRESH_EN
        if (lat < base || lat > base + RC) begin
`else
        if (lat != base) begin
`endif
            bad++;
            $display("FAIL %s: latency %0d, expected %0d", nm, lat, base);
        end
    endtask

    function automatic int base_lat(input int d, input bit we);
        return 1 + wc_of(d) + (we ? 0 : rl_of(d));
    endfunction

    task automatic model_apply(input int d, input bit we, input logic [7:0] a,
                               input logic [1:0] ds, input logic [15:0] din);
        if (we) begin
            if (ds[0]) model_mem[d][a][7:0]  = din[7:0];
            if (ds[1]) model_mem[d][a][15:8] = din[15:8];
        end else begin
            last_rd[d] = model_mem[d][a];
        end
    endtask

    // Toggle one request from the current sample point; latency is the cycle whose end carries the ack edge
    task automatic do_req(input int d, input bit we, input logic [7:0] a, input logic [1:0] ds,
                          input logic [15:0] din, output int lat, output logic [15:0] dout,
                          output int cs_delta);
        int cs0;
        cs0         = cs_cnt[d];
        mem_we[d]   = we;
        mem_addr[d] = a;
        mem_ds[d]   = ds;
        mem_din[d]  = din;
        mem_req[d]  = ~mem_req[d];
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (mem_req_ack[d] == mem_req[d]) begin
                lat = n;
                break;
            end
        end
        dout     = mem_dout[d];
        cs_delta = cs_cnt[d] - cs0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        mem_req = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int d = 0; d < NI; d++) last_rd[d] = 16'h0000;
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [1:0]  ds;
        logic [15:0] din;
        int          lat;
        logic [15:0] dout;
        logic [1:0]  be;
    } vec_t;

    vec_t tab [10];

    initial begin
        int lat, csd, wr0, extra, max_extra;
        logic [15:0] dout, exp_dout;
        bit we;
        int d;
        logic [7:0] a;
        logic [1:0] ds;
        logic [15:0] din;

        tab[0] = '{1'b1, 8'h10, 2'b11, 16'hBEEF, 3, 16'h0000, 2'b11};
        tab[1] = '{1'b0, 8'h10, 2'b00, 16'h5555, 4, 16'hBEEF, 2'b11};
        tab[2] = '{1'b1, 8'h20, 2'b11, 16'hAAAA, 3, 16'hBEEF, 2'b11};
        tab[3] = '{1'b1, 8'h20, 2'b10, 16'h1234, 3, 16'hBEEF, 2'b10};
        tab[4] = '{1'b0, 8'h20, 2'b01, 16'h0000, 4, 16'h12AA, 2'b11};
        tab[5] = '{1'b1, 8'h21, 2'b00, 16'hFFFF, 3, 16'h12AA, 2'b00};
        tab[6] = '{1'b0, 8'h21, 2'b00, 16'h0000, 4, 16'h21DE, 2'b11};
        tab[7] = '{1'b1, 8'h30, 2'b01, 16'h5678, 3, 16'h21DE, 2'b01};
        tab[8] = '{1'b0, 8'h30, 2'b10, 16'h0000, 4, 16'h3078, 2'b11};
        tab[9] = '{1'b0, 8'hFF, 2'b11, 16'h0000, 4, 16'hFF00, 2'b11};

        reset = 1'b1; fill = 1'b1;
        mem_req = '0; mem_we = '0; mem_addr = '0; mem_ds = '0; mem_din = '0;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 256; i++) model_mem[k][i] = fill_val(8'(i));
        end
        @(posedge clk);
        #1;
        fill = 1'b0;
        do_reset();

        // Reset state of every output
        for (int k = 0; k < NI; k++) begin
            check_eq($sformatf("reset_ack_dout_%0d", k), {mem_req_ack[k], mem_dout[k]}, 64'h0);
            check_eq($sformatf("reset_ram_%0d", k),
                     {ram_cs[k], ram_we[k], ram_be[k], ram_addr[k], ram_wdata[k]}, 64'h0);
        end

        // Directed table on instance 0 (WAIT_CYCLES=2, RAM_RD_LAT=1)
        for (int i = 0; i < 10; i++) begin
            do_req(0, tab[i].we, tab[i].addr, tab[i].ds, tab[i].din, lat, dout, csd);
            check_lat($sformatf("tab%0d_lat", i), lat, tab[i].lat);
            check_eq($sformatf("tab%0d_dout", i), 64'(dout), 64'(tab[i].dout));
            check_eq($sformatf("tab%0d_cs_once", i), 64'(csd), 64'd1);
            check_eq($sformatf("tab%0d_be", i), 64'(last_be[0]), 64'(tab[i].be));
            model_apply(0, tab[i].we, tab[i].addr, tab[i].ds, tab[i].din);
        end

        // Back-to-back pair: second toggle in the first idle cycle, dout stable across that cycle
        do_req(0, 1'b0, 8'h20, 2'b11, 16'h0000, lat, dout, csd);
        check_lat("b2b_first_lat", lat, 4);
        check_eq("b2b_first_dout", 64'(dout), 64'h12AA);
        #7;
        check_eq("b2b_dout_stable", 64'(mem_dout[0]), 64'h12AA);
        do_req(0, 1'b0, 8'h30, 2'b11, 16'h0000, lat, dout, csd);
        check_lat("b2b_second_lat", lat, 4);
        check_eq("b2b_second_dout", 64'(dout), 64'h3078);
        last_rd[0] = 16'h3078;

        // Instance 1: no wait states, two-cycle RAM read
        do_req(1, 1'b1, 8'h44, 2'b11, 16'hC0DE, lat, dout, csd);
        check_lat("wc0_write_lat", lat, 1);
        model_apply(1, 1'b1, 8'h44, 2'b11, 16'hC0DE);
        do_req(1, 1'b0, 8'h44, 2'b11, 16'h0000, lat, dout, csd);
        check_lat("wc0_read_lat", lat, 3);
        check_eq("wc0_read_dout", 64'(dout), 64'hC0DE);
        check_eq("wc0_read_cs_once", 64'(csd), 64'd1);
        model_apply(1, 1'b0, 8'h44, 2'b11, 16'h0000);

        // Randomized traffic on both instances against the scoreboard
        for (int it = 0; it < 300; it++) begin
            d  = int'($urandom_range(1, 0));
            we = 1'($urandom_range(1, 0));
            a  = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'($urandom_range(31, 0));
            ds = 2'($urandom);
            din = 16'($urandom);
            exp_dout = we ? last_rd[d] : model_mem[d][a];
            do_req(d, we, a, ds, din, lat, dout, csd);
            check_lat($sformatf("rnd%0d_lat", it), lat, base_lat(d, we));
            check_eq($sformatf("rnd%0d_dout", it), 64'(dout), 64'(exp_dout));
            model_apply(d, we, a, ds, din);
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset during the WAIT phase of a write abandons it; the still-high toggle is served once
        do_reset();
        wr0 = wr_cnt[0];
        mem_we[0] = 1'b1; mem_addr[0] = 8'h50; mem_ds[0] = 2'b11; mem_din[0] = 16'h7777;
        mem_req[0] = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mid_ack", 64'(mem_req_ack[0]), 64'h0);
        check_eq("rst_mid_no_write", 64'(wr_cnt[0]), 64'(wr0));
        check_eq("rst_mid_ram_intact", 64'(ram_arr[0][8'h50]), 64'(model_mem[0][8'h50]));
        reset = 1'b0;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (mem_req_ack[0] == 1'b1) begin
                lat = n;
                break;
            end
        end
        check_lat("rst_rerun_lat", lat, 3);
        model_apply(0, 1'b1, 8'h50, 2'b11, 16'h7777);
        repeat (6) @(posedge clk);
        #1;
        check_eq("rst_single_ack", 64'(mem_req_ack[0]), 64'h1);
        check_eq("rst_single_write", 64'(wr_cnt[0]), 64'(wr0 + 1));
        do_req(0, 1'b0, 8'h50, 2'b11, 16'h0000, lat, dout, csd);
        check_eq("rst_readback", 64'(dout), 64'h7777);

`ifdef MEM_RSP_REFRESH_EN
        // Sweep the request start over a full refresh period; the worst delay is one whole refresh
        max_extra = 0;
        for (int k = 0; k < RP + 4; k++) begin
            do_reset();
            repeat (k) begin
                @(posedge clk);
                #1;
            end
            do_req(0, 1'b0, 8'h10, 2'b11, 16'h0000, lat, dout, csd);
            check_lat($sformatf("ref%0d_lat", k), lat, 4);
            check_eq($sformatf("ref%0d_dout", k), 64'(dout), 64'(model_mem[0][8'h10]));
            extra = lat - 4;
            if (extra > max_extra) max_extra = extra;
        end
        check_eq("refresh_max_delay", 64'(max_extra), 64'(RC));
`else
        max_extra = 0;
        extra = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
